// File: rtl/riscv_ahb3_slave_sram_if.sv
// AHB3-Lite bus bundle between one RISC-V core master port (ins_* or dat_*)
// and the riscv_ahb3_slave_sram backing store.
interface riscv_ahb3_slave_sram_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PLEN = 64
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/riscv_ahb3_slave_sram.sv
// AHB3-Lite slave SRAM with programmable wait states and byte-lane writes.
// Define RISCV_AHB3_SRAM_ERROR_EN to enable illegal-transfer decode and the two-cycle ERROR response.
module riscv_ahb3_slave_sram #(
    parameter int unsigned     XLEN        = 64,
    parameter int unsigned     PLEN        = 64,
    parameter int unsigned     MEM_DEPTH   = 1024,
    parameter logic [PLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_ahb3_slave_sram_if.slave ahb
);
    localparam int unsigned   BYTES = XLEN / 8;
    localparam int unsigned   OFFW  = $clog2(BYTES);
    localparam int unsigned   IDXW  = $clog2(MEM_DEPTH);
    localparam logic [PLEN:0] SPAN  = (PLEN+1)'(MEM_DEPTH) * (PLEN+1)'(BYTES);

`ifdef RISCV_AHB3_SRAM_ERROR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_DATA} state_t;
`endif

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDXW-1:0]   a_idx;
    logic [OFFW-1:0]   a_off;
    logic [2:0]        a_size;
    logic              a_write;

    logic              ready;
    logic              accept;
    logic              legal;
    logic              commit;
    logic [PLEN:0]     rel_addr;
    logic [IDXW-1:0]   req_idx;
    logic [OFFW-1:0]   req_off;
    logic [BYTES-1:0]  wr_be;
    logic [XLEN-1:0]   mem [MEM_DEPTH];

    // Borrow lands in the MSB, so addresses below BASE_ADDR compare as out of range.
    assign rel_addr = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
    assign req_idx  = rel_addr[OFFW +: IDXW];
    assign req_off  = ahb.HADDR[OFFW-1:0];

`ifdef RISCV_AHB3_SRAM_ERROR_EN
    logic [OFFW-1:0] align_mask;
    always_comb begin
        align_mask = '0;
        for (int unsigned b = 0; b < OFFW; b++)
            if (b < 32'(ahb.HSIZE)) align_mask[b] = 1'b1;
        legal = !((32'(ahb.HSIZE) > OFFW) || (|(req_off & align_mask)) || (rel_addr >= SPAN));
    end
`else
    assign legal = 1'b1;
`endif

    always_comb begin
        ready = 1'b1;
        unique case (state_q)
            ST_DATA: ready = (cnt_q == '0);
`ifdef RISCV_AHB3_SRAM_ERROR_EN
            ST_ERR1: ready = 1'b0;
`endif
            default: ready = 1'b1;
        endcase
    end

    assign accept = ready && ahb.HSEL && ahb.HTRANS[1];
    assign commit = (state_q == ST_DATA) && ready && a_write;

    // A completing data phase either retires to IDLE or chains straight into the next transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef RISCV_AHB3_SRAM_ERROR_EN
        if (state_q == ST_ERR1) state_d = ST_ERR2;
`endif
        if (state_q == ST_DATA && cnt_q != '0) cnt_d = cnt_q - 4'd1;
        if (ready) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (accept) begin
`ifdef RISCV_AHB3_SRAM_ERROR_EN
                state_d = legal ? ST_DATA : ST_ERR1;
                cnt_d   = legal ? 4'(WAIT_STATES) : '0;
`else
                state_d = ST_DATA;
                cnt_d   = 4'(WAIT_STATES);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_idx   <= '0;
            a_off   <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_idx   <= req_idx;
                a_off   <= req_off;
                a_size  <= ahb.HSIZE;
                a_write <= ahb.HWRITE && legal;
            end
        end
    end

    // Lanes past the end of the word are clipped rather than wrapped.
    always_comb begin
        wr_be = '0;
        for (int unsigned b = 0; b < BYTES; b++)
            wr_be[b] = (b >= 32'(a_off)) && (b < 32'(a_off) + (32'd1 << a_size));
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < BYTES; b++)
                if (wr_be[b]) mem[a_idx][8*b +: 8] <= ahb.HWDATA[8*b +: 8];
        end
    end

    assign ahb.HREADY = ready;
    assign ahb.HRDATA = (state_q == ST_DATA) ? mem[a_idx] : '0;
`ifdef RISCV_AHB3_SRAM_ERROR_EN
    assign ahb.HRESP  = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign ahb.HRESP  = 1'b0;
`endif

    logic unused_sink;
    assign unused_sink = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0], rel_addr};
endmodule

// File: tb/tb_riscv_ahb3_slave_sram.sv
// Directed bench for riscv_ahb3_slave_sram: one zero-wait instance and one three-wait instance.
// Expectations for illegal transfers follow RISCV_AHB3_SRAM_ERROR_EN.
module tb_riscv_ahb3_slave_sram;
    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    riscv_ahb3_slave_sram_if #(.XLEN(64), .PLEN(64)) bus0 ();
    riscv_ahb3_slave_sram_if #(.XLEN(64), .PLEN(64)) bus3 ();

    riscv_ahb3_slave_sram #(
        .XLEN(64), .PLEN(64), .MEM_DEPTH(1024), .BASE_ADDR(64'h0), .WAIT_STATES(0)
    ) dut0 (.clk(clk), .rst(rst), .ahb(bus0.slave));

    riscv_ahb3_slave_sram #(
        .XLEN(64), .PLEN(64), .MEM_DEPTH(1024), .BASE_ADDR(64'h0), .WAIT_STATES(3)
    ) dut3 (.clk(clk), .rst(rst), .ahb(bus3.slave));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr0(input logic sel, input logic [1:0] trans, input logic [63:0] addr,
                         input logic wr, input logic [2:0] size);
        bus0.HSEL = sel; bus0.HTRANS = trans; bus0.HADDR = addr;
        bus0.HWRITE = wr; bus0.HSIZE = size;
    endtask

    task automatic idle0();
        bus0.HSEL = 1'b0; bus0.HTRANS = T_IDLE; bus0.HWRITE = 1'b0;
    endtask

    task automatic addr3(input logic [1:0] trans, input logic [63:0] addr, input logic wr);
        bus3.HSEL = 1'b1; bus3.HTRANS = trans; bus3.HADDR = addr;
        bus3.HWRITE = wr; bus3.HSIZE = 3'd3;
    endtask

    task automatic idle3();
        bus3.HSEL = 1'b0; bus3.HTRANS = T_IDLE; bus3.HWRITE = 1'b0;
    endtask

    // Returns at the falling edge where HREADY is first seen high; gives up after 20 low cycles.
    task automatic wait_ready3(output int unsigned lows);
        bit done;
        done = 1'b0;
        lows = 0;
        while (!done && lows < 20) begin
            @(negedge clk);
            if (bus3.HREADY === 1'b1) done = 1'b1;
            else begin
                lows++;
                cyc();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle0(); idle3();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL reset_hready0 got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp0 got=%b exp=0", bus0.HRESP); end
        checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL reset_hrdata0 got=%h exp=0", bus0.HRDATA); end
        checks++; if (bus3.HREADY !== 1'b1) begin failures++; $display("FAIL reset_hready3 got=%b exp=1", bus3.HREADY); end
        checks++; if (bus3.HRDATA !== 64'h0) begin failures++; $display("FAIL reset_hrdata3 got=%h exp=0", bus3.HRDATA); end
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_dword_rw();
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b1, 3'd3);
        cyc();
        bus0.HWDATA = 64'h1122334455667788;
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL dword_wr_ready got=%b exp=1", bus0.HREADY); end
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL dword_rd_ready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRDATA !== 64'h1122334455667788) begin failures++; $display("FAIL dword_rd_data got=%h exp=%h", bus0.HRDATA, 64'h1122334455667788); end
        cyc();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL idle_hrdata got=%h exp=0", bus0.HRDATA); end
        cyc();
    endtask

    task automatic test_reset_mid_write();
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b1, 3'd3);
        cyc();
        bus0.HWDATA = 64'hFFFF_FFFF_FFFF_FFFF;
        idle0();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL midrst_hready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL midrst_hresp got=%b exp=0", bus0.HRESP); end
        checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL midrst_hrdata got=%h exp=0", bus0.HRDATA); end
        cyc(); cyc(); cyc();
        rst = 1'b1;
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h1122334455667788) begin failures++; $display("FAIL midrst_kept got=%h exp=%h", bus0.HRDATA, 64'h1122334455667788); end
        cyc();
    endtask

    task automatic test_byte_write();
        addr0(1'b1, T_NONSEQ, 64'h43, 1'b1, 3'd0);
        cyc();
        bus0.HWDATA = 64'hFFFF_FFFF_AAFF_FFFF;
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL byte_wr_ready got=%b exp=1", bus0.HREADY); end
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL byte_rd_ready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRDATA !== 64'h11223344AA667788) begin failures++; $display("FAIL byte_rd_data got=%h exp=%h", bus0.HRDATA, 64'h11223344AA667788); end
        cyc();
    endtask

    task automatic test_idle_busy();
        addr0(1'b1, T_BUSY, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL busy_no_capture got=%h exp=0", bus0.HRDATA); end
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL busy_ready got=%b exp=1", bus0.HREADY); end
        cyc();
        addr0(1'b0, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h0) begin failures++; $display("FAIL unsel_no_capture got=%h exp=0", bus0.HRDATA); end
        cyc();
    endtask

    task automatic test_wait_states();
        int unsigned lows;
        addr3(T_NONSEQ, 64'h40, 1'b1);
        cyc();
        bus3.HWDATA = 64'hA5A5_0000_1111_2222;
        addr3(T_SEQ, 64'h48, 1'b1);
        wait_ready3(lows);
        checks++; if (lows != 3) begin failures++; $display("FAIL ws_wr1_lows got=%0d exp=3", lows); end
        cyc();
        bus3.HWDATA = 64'h5A5A_3333_4444_FFFF;
        addr3(T_NONSEQ, 64'h40, 1'b0);
        wait_ready3(lows);
        checks++; if (lows != 3) begin failures++; $display("FAIL ws_wr2_lows got=%0d exp=3", lows); end
        cyc();
        addr3(T_SEQ, 64'h48, 1'b0);
        wait_ready3(lows);
        checks++; if (lows != 3) begin failures++; $display("FAIL ws_rd1_lows got=%0d exp=3", lows); end
        checks++; if (bus3.HRDATA !== 64'hA5A5_0000_1111_2222) begin failures++; $display("FAIL ws_rd1_data got=%h exp=%h", bus3.HRDATA, 64'hA5A5_0000_1111_2222); end
        cyc();
        idle3();
        wait_ready3(lows);
        checks++; if (lows != 3) begin failures++; $display("FAIL ws_rd2_lows got=%0d exp=3", lows); end
        checks++; if (bus3.HRDATA !== 64'h5A5A_3333_4444_FFFF) begin failures++; $display("FAIL ws_rd2_data got=%h exp=%h", bus3.HRDATA, 64'h5A5A_3333_4444_FFFF); end
        cyc();
        @(negedge clk);
        checks++; if (bus3.HREADY !== 1'b1) begin failures++; $display("FAIL ws_idle_ready got=%b exp=1", bus3.HREADY); end
        checks++; if (bus3.HRDATA !== 64'h0) begin failures++; $display("FAIL ws_idle_data got=%h exp=0", bus3.HRDATA); end
        cyc();
    endtask

    task automatic test_misaligned();
        addr0(1'b1, T_NONSEQ, 64'h41, 1'b1, 3'd1);
        cyc();
        bus0.HWDATA = 64'hFFFF_FFFF_FFBB_CCFF;
        idle0();
        @(negedge clk);
`ifdef RISCV_AHB3_SRAM_ERROR_EN
        checks++; if (bus0.HREADY !== 1'b0) begin failures++; $display("FAIL mis_err1_ready got=%b exp=0", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b1) begin failures++; $display("FAIL mis_err1_resp got=%b exp=1", bus0.HRESP); end
        cyc();
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL mis_err2_ready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b1) begin failures++; $display("FAIL mis_err2_resp got=%b exp=1", bus0.HRESP); end
        cyc();
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h11223344AA667788) begin failures++; $display("FAIL mis_unchanged got=%h exp=%h", bus0.HRDATA, 64'h11223344AA667788); end
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL mis_after_resp got=%b exp=0", bus0.HRESP); end
        cyc();
`else
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL mis_ok_ready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL mis_ok_resp got=%b exp=0", bus0.HRESP); end
        cyc();
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h11223344AABBCC88) begin failures++; $display("FAIL mis_half_data got=%h exp=%h", bus0.HRDATA, 64'h11223344AABBCC88); end
        cyc();
        addr0(1'b1, T_NONSEQ, 64'h45, 1'b1, 3'd3);
        cyc();
        bus0.HWDATA = 64'h0102030405060708;
        addr0(1'b1, T_NONSEQ, 64'h40, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRDATA !== 64'h01020344AABBCC88) begin failures++; $display("FAIL clip_data got=%h exp=%h", bus0.HRDATA, 64'h01020344AABBCC88); end
        cyc();
`endif
    endtask

    task automatic test_range();
        addr0(1'b1, T_NONSEQ, 64'h0, 1'b1, 3'd3);
        cyc();
        bus0.HWDATA = 64'hCAFEF00D12345678;
        addr0(1'b1, T_NONSEQ, 64'h2000, 1'b0, 3'd3);
        cyc();
        idle0();
        @(negedge clk);
`ifdef RISCV_AHB3_SRAM_ERROR_EN
        checks++; if (bus0.HREADY !== 1'b0) begin failures++; $display("FAIL oor_err1_ready got=%b exp=0", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b1) begin failures++; $display("FAIL oor_err1_resp got=%b exp=1", bus0.HRESP); end
        cyc();
        addr0(1'b1, T_NONSEQ, 64'h0, 1'b0, 3'd3);
        @(negedge clk);
        checks++; if (bus0.HREADY !== 1'b1) begin failures++; $display("FAIL oor_err2_ready got=%b exp=1", bus0.HREADY); end
        checks++; if (bus0.HRESP !== 1'b1) begin failures++; $display("FAIL oor_err2_resp got=%b exp=1", bus0.HRESP); end
        cyc();
        idle0();
        @(negedge clk);
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL oor_next_resp got=%b exp=0", bus0.HRESP); end
        checks++; if (bus0.HRDATA !== 64'hCAFEF00D12345678) begin failures++; $display("FAIL oor_next_data got=%h exp=%h", bus0.HRDATA, 64'hCAFEF00D12345678); end
        cyc();
`else
        checks++; if (bus0.HRESP !== 1'b0) begin failures++; $display("FAIL wrap_resp got=%b exp=0", bus0.HRESP); end
        checks++; if (bus0.HRDATA !== 64'hCAFEF00D12345678) begin failures++; $display("FAIL wrap_data got=%h exp=%h", bus0.HRDATA, 64'hCAFEF00D12345678); end
        cyc();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.HBURST = '0; bus0.HPROT = '0; bus0.HMASTLOCK = 1'b0; bus0.HADDR = '0;
        bus0.HWDATA = '0; bus0.HSIZE = '0;
        bus3.HBURST = '0; bus3.HPROT = '0; bus3.HMASTLOCK = 1'b0; bus3.HADDR = '0;
        bus3.HWDATA = '0; bus3.HSIZE = '0;
        test_reset();
        test_dword_rw();
        test_reset_mid_write();
        test_byte_write();
        test_idle_busy();
        test_wait_states();
        test_misaligned();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
